uart_cmd_parser: RTL and testbench
==================================

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 Parameter ARG_DIGITS, default 6, sets the decimal digits in a set-time argument (HHMMSS).
REQ-002 Parameter TIMEOUT_CYCLES, default 100_000_000, sets the idle cycles allowed between argument bytes (1 s at 100 MHz).
REQ-003 Parameter SET_CHAR, default 8'h54 ('T'), is the set-command letter; its lower-case form (+8'h20) is equally accepted.
REQ-004 clk  in  1  system clock; single clock domain, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 data_in  in  8  received ASCII byte; valid only when ctrl_data=1.
REQ-007 ctrl_data  in  1  one-cycle byte-valid strobe from the UART receiver.
REQ-008 uart_sec, uart_min, uart_hour, uart_run, uart_clear, uart_special  out  1 each  registered one-cycle command pulses.
REQ-009 arg_valid  out  1  one-cycle pulse: new argument accepted.
REQ-010 arg_data  out  4*ARG_DIGITS  BCD argument; first digit received in the MS nibble.
REQ-011 arg_err  out  1  one-cycle pulse: argument sequence aborted.
REQ-012 arg_busy  out  1  high while in the ARG state.

Function
REQ-013 Bytes are sampled only on cycles with ctrl_data=1; all outputs are registered, so each pulse appears exactly 1 cycle after the sampling edge.
REQ-014 IDLE, byte 'S'/'s', 'M'/'m', 'H'/'h', 'R'/'r', 'C'/'c' or 'I'/'i' -> pulse uart_sec, uart_min, uart_hour, uart_run, uart_clear or uart_special respectively; state stays IDLE.
REQ-015 IDLE, byte equal to SET_CHAR (either case) -> ARG; digit count cleared, shift register cleared, timer loaded.
REQ-016 IDLE, any other byte (including CR, LF, ESC, digits) -> ignored: no pulse, no error.
REQ-017 ARG, digit 0x30-0x39 with count<ARG_DIGITS -> shift the nibble in, count+1, timer reloaded.
REQ-018 ARG, digit with count==ARG_DIGITS -> arg_err, IDLE.
REQ-019 ARG, CR (0x0D) or LF (0x0A) with count==ARG_DIGITS -> arg_valid, arg_data updated in the same cycle as arg_valid, IDLE.
REQ-020 ARG, CR/LF with count<ARG_DIGITS -> arg_err, IDLE; arg_data unchanged.
REQ-021 ARG, ESC (0x1B) or any other non-digit byte, including command letters -> arg_err, IDLE; no command pulse.
REQ-022 ARG, no byte for TIMEOUT_CYCLES consecutive cycles -> arg_err, IDLE.
REQ-023 Byte arrival on the cycle the timer expires -> the byte is processed and the timeout is discarded.
REQ-024 arg_data holds its last accepted value until the next arg_valid.
REQ-025 Timer width is $clog2(TIMEOUT_CYCLES+1); the timer counts down and saturates at 0; it runs only in ARG.
REQ-026 At most one output pulse is asserted per cycle.

Reset
REQ-027 rst=1 at a clock edge -> state IDLE, all pulses 0, arg_busy 0, arg_data 0, count 0, timer 0.
REQ-028 rst during ARG aborts without arg_err; a byte sampled in the reset cycle is discarded.

Structure
REQ-029 Package uart_cmd_pkg holds the ASCII constants (command letters, CR, LF, ESC, '0', '9') and the state encoding IDLE/ARG.
REQ-030 Sub-module uart_cmd_timeout (load, enable, expire) implements the REQ-022/023/025 timer; the rest is a single FSM with the shift register.

Verification (bench: ARG_DIGITS=6, TIMEOUT_CYCLES=16)
REQ-031 Bytes 's', 'M', 'h', 'r', 'C', 'i', 'x' -> one 1-cycle pulse each on the matching output one cycle later; 'x' gives no pulse.
REQ-032 'T','1','2','3','4','5','6',CR -> arg_valid once, arg_data=24'h123456, arg_busy low afterwards.
REQ-033 't','0','9',LF -> arg_err, arg_data keeps 24'h123456; then 'T','1','2','3','4','5','6','7' -> arg_err on the 7th digit.
REQ-034 'T','1', then 16 idle cycles -> arg_err; repeat with the next byte landing on the expiry cycle -> no arg_err, the digit is accepted.
REQ-035 'T','1','S' -> arg_err, no uart_sec; 'T', ESC -> arg_err.
REQ-036 'T','1','2', then rst for 1 cycle -> no arg_err, all outputs 0, next 'R' -> uart_run pulse.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and byte-classification helpers for the
// UART command parser.
package uart_cmd_pkg;

    localparam logic [7:0] CHR_S       = 8'h53;
    localparam logic [7:0] CHR_M       = 8'h4D;
    localparam logic [7:0] CHR_H       = 8'h48;
    localparam logic [7:0] CHR_R       = 8'h52;
    localparam logic [7:0] CHR_C       = 8'h43;
    localparam logic [7:0] CHR_I       = 8'h49;
    localparam logic [7:0] CHR_T       = 8'h54;
    localparam logic [7:0] CHR_CR      = 8'h0D;
    localparam logic [7:0] CHR_LF      = 8'h0A;
    localparam logic [7:0] CHR_ESC     = 8'h1B;
    localparam logic [7:0] CHR_0       = 8'h30;
    localparam logic [7:0] CHR_9       = 8'h39;
    localparam logic [7:0] CASE_OFFSET = 8'h20;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ARG  = 1'b1
    } state_t;

    // One bit per registered output pulse; at most one is set in any cycle.
    typedef struct packed {
        logic sec;
        logic min;
        logic hour;
        logic run;
        logic clear;
        logic special;
        logic valid;
        logic err;
    } pulse_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= CHR_0) && (b <= CHR_9);
    endfunction

    // Matches an upper-case letter or its lower-case form.
    function automatic logic is_letter(input logic [7:0] b, input logic [7:0] upper);
        return (b == upper) || (b == upper + CASE_OFFSET);
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout counter: loads on each accepted byte, counts down while
// enabled, saturates at zero, and flags the cycle on which it would reach zero.
module uart_cmd_timeout
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] LAST_VAL = TMR_W'(1);

    logic [TMR_W-1:0] tmr_q, tmr_d;

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        tmr_d = tmr_q;
        if (load) begin
            tmr_d = LOAD_VAL;
        end else if (enable && (tmr_q != '0)) begin
            tmr_d = tmr_q - 1'b1;
        end
    end

    // The count leaves 1 on the TIMEOUT_CYCLES-th idle cycle after a load.
    assign expire = enable && (tmr_q == LAST_VAL);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Decodes single-letter UART commands into one-cycle pulses and collects a
// BCD set-time argument terminated by CR/LF, with an inter-byte timeout.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned ARG_DIGITS     = 6,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter logic [7:0]  SET_CHAR       = CHR_T
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              data_in,
    input  logic                    ctrl_data,
    output logic                    uart_sec,
    output logic                    uart_min,
    output logic                    uart_hour,
    output logic                    uart_run,
    output logic                    uart_clear,
    output logic                    uart_special,
    output logic                    arg_valid,
    output logic [4*ARG_DIGITS-1:0] arg_data,
    output logic                    arg_err,
    output logic                    arg_busy
);

    localparam int unsigned ARG_W = 4 * ARG_DIGITS;
    localparam int unsigned CNT_W = $clog2(ARG_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ARG_DIGITS);

    state_t           state_q, state_d;
    pulse_t           pulse_q, pulse_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ARG_W-1:0] sreg_q, sreg_d;
    logic [ARG_W-1:0] arg_data_q, arg_data_d;
    logic             tmr_load;
    logic             tmr_expire;
    logic             abort;

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .enable(state_q == ST_ARG),
        .expire(tmr_expire)
    );

    always_comb begin
        state_d    = state_q;
        pulse_d    = '0;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        arg_data_d = arg_data_q;
        tmr_load   = 1'b0;
        abort      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_data) begin
                    if (is_letter(data_in, SET_CHAR)) begin
                        state_d  = ST_ARG;
                        cnt_d    = '0;
                        sreg_d   = '0;
                        tmr_load = 1'b1;
                    end else begin
                        pulse_d.sec     = is_letter(data_in, CHR_S);
                        pulse_d.min     = is_letter(data_in, CHR_M);
                        pulse_d.hour    = is_letter(data_in, CHR_H);
                        pulse_d.run     = is_letter(data_in, CHR_R);
                        pulse_d.clear   = is_letter(data_in, CHR_C);
                        pulse_d.special = is_letter(data_in, CHR_I);
                    end
                end
            end

            ST_ARG: begin
                // A byte on the expiry cycle wins; the timeout is dropped.
                if (ctrl_data) begin
                    case (data_in)
                        CHR_CR, CHR_LF: begin
                            if (cnt_q == CNT_FULL) begin
                                pulse_d.valid = 1'b1;
                                arg_data_d    = sreg_q;
                                state_d       = ST_IDLE;
                            end else begin
                                abort = 1'b1;
                            end
                        end
                        CHR_ESC: abort = 1'b1;
                        default: begin
                            if (is_digit(data_in) && (cnt_q < CNT_FULL)) begin
                                sreg_d   = {sreg_q[ARG_W-5:0], data_in[3:0]};
                                cnt_d    = cnt_q + 1'b1;
                                tmr_load = 1'b1;
                            end else begin
                                abort = 1'b1;
                            end
                        end
                    endcase
                end else if (tmr_expire) begin
                    abort = 1'b1;
                end

                if (abort) begin
                    pulse_d.err = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pulse_q    <= '0;
            cnt_q      <= '0;
            sreg_q     <= '0;
            arg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            arg_data_q <= arg_data_d;
        end
    end

    assign uart_sec     = pulse_q.sec;
    assign uart_min     = pulse_q.min;
    assign uart_hour    = pulse_q.hour;
    assign uart_run     = pulse_q.run;
    assign uart_clear   = pulse_q.clear;
    assign uart_special = pulse_q.special;
    assign arg_valid    = pulse_q.valid;
    assign arg_err      = pulse_q.err;
    assign arg_data     = arg_data_q;
    assign arg_busy     = (state_q == ST_ARG);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (6 digits, 16-cycle timeout).
module tb_uart_cmd_parser;

    localparam int unsigned ARG_DIGITS     = 6;
    localparam int unsigned TIMEOUT_CYCLES = 16;

    // Pulse vector order: {sec, min, hour, run, clear, special, valid, err}.
    localparam logic [7:0] P_NONE = 8'h00;
    localparam logic [7:0] P_SEC  = 8'h80;
    localparam logic [7:0] P_MIN  = 8'h40;
    localparam logic [7:0] P_HOUR = 8'h20;
    localparam logic [7:0] P_RUN  = 8'h10;
    localparam logic [7:0] P_CLR  = 8'h08;
    localparam logic [7:0] P_SPC  = 8'h04;
    localparam logic [7:0] P_VAL  = 8'h02;
    localparam logic [7:0] P_ERR  = 8'h01;

    logic                    clk;
    logic                    rst;
    logic [7:0]              data_in;
    logic                    ctrl_data;
    logic                    uart_sec, uart_min, uart_hour, uart_run;
    logic                    uart_clear, uart_special;
    logic                    arg_valid, arg_err, arg_busy;
    logic [4*ARG_DIGITS-1:0] arg_data;
    logic [7:0]              pulses;

    int n_checks = 0;
    int n_fail   = 0;

    uart_cmd_parser #(
        .ARG_DIGITS    (ARG_DIGITS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SET_CHAR      (8'h54)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .ctrl_data   (ctrl_data),
        .uart_sec    (uart_sec),
        .uart_min    (uart_min),
        .uart_hour   (uart_hour),
        .uart_run    (uart_run),
        .uart_clear  (uart_clear),
        .uart_special(uart_special),
        .arg_valid   (arg_valid),
        .arg_data    (arg_data),
        .arg_err     (arg_err),
        .arg_busy    (arg_busy)
    );

    assign pulses = {uart_sec, uart_min, uart_hour, uart_run,
                     uart_clear, uart_special, arg_valid, arg_err};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the byte is sampled on the following posedge and the
    // registered response is checked at the negedge after it.
    task automatic send(input logic [7:0] b, input logic [7:0] exp, input string tag);
        data_in   = b;
        ctrl_data = 1'b1;
        @(negedge clk);
        ctrl_data = 1'b0;
        data_in   = 8'h00;
        check(tag, {24'h0, pulses}, {24'h0, exp});
    endtask

    // Sends a string whose bytes must all produce no pulse and keep ARG busy.
    task automatic send_quiet(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], P_NONE, $sformatf("%s[%0d]", tag, i));
            check($sformatf("%s_busy[%0d]", tag, i), {31'h0, arg_busy}, 32'h1);
        end
    endtask

    logic [7:0] cmd_bytes [10] = '{8'h73, 8'h4D, 8'h68, 8'h72, 8'h43, 8'h69,
                                   8'h78, 8'h0D, 8'h35, 8'h1B};
    logic [7:0] cmd_exp   [10] = '{P_SEC, P_MIN, P_HOUR, P_RUN, P_CLR, P_SPC,
                                   P_NONE, P_NONE, P_NONE, P_NONE};

    initial begin
        rst       = 1'b1;
        ctrl_data = 1'b0;
        data_in   = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_pulses", {24'h0, pulses}, 32'h0);
        check("rst_busy", {31'h0, arg_busy}, 32'h0);
        check("rst_data", {8'h0, arg_data}, 32'h0);

        // Single-letter commands and ignored bytes in IDLE.
        for (int i = 0; i < 10; i++) begin
            send(cmd_bytes[i], cmd_exp[i], $sformatf("cmd_%02h", cmd_bytes[i]));
            @(negedge clk);
            check($sformatf("cmd_%02h_width", cmd_bytes[i]), {24'h0, pulses}, 32'h0);
        end

        // Full set-time argument.
        send_quiet("T123456", "set");
        send(8'h0D, P_VAL, "set_cr");
        check("set_data", {8'h0, arg_data}, 32'h00123456);
        check("set_busy_after", {31'h0, arg_busy}, 32'h0);
        @(negedge clk);
        check("set_valid_width", {24'h0, pulses}, 32'h0);

        // Short argument terminated by LF.
        send_quiet("t09", "short");
        send(8'h0A, P_ERR, "short_lf");
        check("short_data_kept", {8'h0, arg_data}, 32'h00123456);
        check("short_busy", {31'h0, arg_busy}, 32'h0);

        // Seven digits.
        send_quiet("T123456", "long");
        send(8'h37, P_ERR, "long_7th");
        check("long_busy", {31'h0, arg_busy}, 32'h0);
        check("long_data_kept", {8'h0, arg_data}, 32'h00123456);

        // Timeout: 16 idle cycles after the last byte abort the argument.
        send_quiet("T1", "tmo");
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("tmo_idle%0d", i), {24'h0, pulses}, 32'h0);
        end
        @(negedge clk);
        check("tmo_expire", {24'h0, pulses}, {24'h0, P_ERR});
        check("tmo_busy", {31'h0, arg_busy}, 32'h0);

        // Byte landing on the expiry cycle is accepted and reloads the timer.
        send_quiet("T9", "tmo2");
        repeat (15) @(negedge clk);
        send(8'h38, P_NONE, "tmo2_edge_byte");
        check("tmo2_busy", {31'h0, arg_busy}, 32'h1);
        send_quiet("7654", "tmo2_rest");
        send(8'h0D, P_VAL, "tmo2_cr");
        check("tmo2_data", {8'h0, arg_data}, 32'h00987654);

        // Command letter or ESC inside an argument aborts it.
        send_quiet("T1", "abort_s");
        send(8'h53, P_ERR, "abort_s_letter");
        send_quiet("T", "abort_esc");
        send(8'h1B, P_ERR, "abort_esc_byte");
        check("abort_data_kept", {8'h0, arg_data}, 32'h00987654);

        // Reset mid-argument, with an 'S' sampled during the reset cycle.
        send_quiet("T12", "rst_arg");
        rst       = 1'b1;
        data_in   = 8'h53;
        ctrl_data = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        ctrl_data = 1'b0;
        data_in   = 8'h00;
        check("rst_arg_pulses", {24'h0, pulses}, 32'h0);
        check("rst_arg_busy", {31'h0, arg_busy}, 32'h0);
        check("rst_arg_data", {8'h0, arg_data}, 32'h0);
        @(negedge clk);
        check("rst_arg_quiet", {24'h0, pulses}, 32'h0);
        send(8'h52, P_RUN, "rst_arg_run");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
